// File: rtl/pxs_sync_gen_pkg.sv
// Shared definitions for the Pxs pixel stream: field layout, pattern modes
// and the colour-bar helper used by the sync generator.
package pxs_sync_gen_pkg;

  localparam int CNT_W    = 10;
  localparam int STREAM_W = 26;

  typedef enum logic [1:0] {
    MODE_BLACK   = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_SOLID   = 2'd3
  } pattern_e;

  // Packed MSB-first so the struct maps directly onto the 26-bit stream word.
  typedef struct packed {
    logic             hs;
    logic             vs;
    logic             active;
    logic [CNT_W-1:0] yc;
    logic [CNT_W-1:0] xc;
    logic [2:0]       rgb;
  } pxs_stream_t;

  // Bar index found by comparing against the seven bar boundaries, brightest bar first.
  function automatic logic [2:0] bar_colour(input logic [CNT_W-1:0] x, input int visible);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (int'(x) >= (k * visible) / 8) begin
        idx = idx + 3'd1;
      end else begin
        idx = idx;
      end
    end
    return 3'd7 - idx;
  endfunction

endpackage

// File: rtl/pxs_axis_counter.sv
// One timing axis: wrapping position counter with visible and active-low
// sync decodes. Used once per line (horizontal) and once per frame (vertical).
module pxs_axis_counter #(
  parameter int TOTAL      = 800,
  parameter int SYNC_START = 656,
  parameter int SYNC_END   = 752,
  parameter int VISIBLE    = 640
) (
  input  logic       px_clk,
  input  logic       reset,
  input  logic       advance,
  output logic [9:0] count,
  output logic       wrap,
  output logic       visible,
  output logic       sync_n
);

  localparam logic [9:0] LAST = 10'(TOTAL - 1);

  logic [9:0] count_q;
  logic [9:0] count_d;

  always_comb begin
    wrap    = advance && (count_q == LAST);
    count_d = count_q;
    if (wrap) begin
      count_d = 10'd0;
    end else if (advance) begin
      count_d = count_q + 10'd1;
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge px_clk or posedge reset) begin
    if (reset) begin
      count_q <= 10'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign visible = (count_q < 10'(VISIBLE));
  assign sync_n  = !((count_q >= 10'(SYNC_START)) && (count_q < 10'(SYNC_END)));

endmodule

// File: rtl/pxs_sync_gen.sv
// Head of the Pxs chain: VGA timing plus a background test pattern, emitted
// as a registered 26-bit pixel stream with a frame_end pulse on the last visible pixel.
module pxs_sync_gen
  import pxs_sync_gen_pkg::*;
#(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        px_clk,
  input  logic        reset,
  input  logic [1:0]  mode,
  input  logic [2:0]  solid_rgb,
  output logic [25:0] RGBStr_o,
  output logic        frame_end
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  logic [9:0] h_count, v_count;
  logic       h_wrap, v_wrap;
  logic       h_vis, v_vis;
  logic       h_sync_n, v_sync_n;

  pxs_axis_counter #(
    .TOTAL(H_TOTAL), .SYNC_START(H_VISIBLE + H_FRONT),
    .SYNC_END(H_VISIBLE + H_FRONT + H_SYNC), .VISIBLE(H_VISIBLE)
  ) u_h_axis (
    .px_clk(px_clk), .reset(reset), .advance(1'b1),
    .count(h_count), .wrap(h_wrap), .visible(h_vis), .sync_n(h_sync_n)
  );

  pxs_axis_counter #(
    .TOTAL(V_TOTAL), .SYNC_START(V_VISIBLE + V_FRONT),
    .SYNC_END(V_VISIBLE + V_FRONT + V_SYNC), .VISIBLE(V_VISIBLE)
  ) u_v_axis (
    .px_clk(px_clk), .reset(reset), .advance(h_wrap),
    .count(v_count), .wrap(v_wrap), .visible(v_vis), .sync_n(v_sync_n)
  );

  pattern_e    mode_q, mode_d;
  logic [2:0]  solid_rgb_q, solid_rgb_d;
  logic        frame_start_q, frame_start_d;
  pxs_stream_t stream_q, stream_d;
  logic        frame_end_q, frame_end_d;
  logic [2:0]  pix_rgb;

  // Pixel (0,0) already uses the freshly sampled mode, so a frame never mixes two patterns.
  always_comb begin
    frame_start_d = v_wrap;
    if (frame_start_q) begin
      mode_d      = pattern_e'(mode);
      solid_rgb_d = solid_rgb;
    end else begin
      mode_d      = mode_q;
      solid_rgb_d = solid_rgb_q;
    end

    pix_rgb = 3'b000;
    if (h_vis && v_vis) begin
      case (mode_d)
        MODE_BLACK:   pix_rgb = 3'b000;
        MODE_BARS:    pix_rgb = bar_colour(h_count, H_VISIBLE);
        MODE_CHECKER: pix_rgb = (h_count[5] ^ v_count[5]) ? 3'b111 : 3'b000;
        MODE_SOLID:   pix_rgb = solid_rgb_d;
        default:      pix_rgb = 3'b000;
      endcase
    end else begin
      pix_rgb = 3'b000;
    end

    stream_d.hs     = h_sync_n;
    stream_d.vs     = v_sync_n;
    stream_d.active = h_vis && v_vis;
    stream_d.yc     = v_count;
    stream_d.xc     = h_count;
    stream_d.rgb    = pix_rgb;

    frame_end_d = (h_count == 10'(H_VISIBLE - 1)) && (v_count == 10'(V_VISIBLE - 1));
  end

  // Counters restart at (0,0) after reset, so the first edge is a frame start.
  always_ff @(posedge px_clk or posedge reset) begin
    if (reset) begin
      mode_q          <= MODE_BLACK;
      solid_rgb_q     <= 3'b000;
      frame_start_q   <= 1'b1;
      stream_q.hs     <= 1'b1;
      stream_q.vs     <= 1'b1;
      stream_q.active <= 1'b0;
      stream_q.yc     <= 10'd0;
      stream_q.xc     <= 10'd0;
      stream_q.rgb    <= 3'b000;
      frame_end_q     <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      solid_rgb_q   <= solid_rgb_d;
      frame_start_q <= frame_start_d;
      stream_q      <= stream_d;
      frame_end_q   <= frame_end_d;
    end
  end

  assign RGBStr_o  = stream_q;
  assign frame_end = frame_end_q;

endmodule

// File: tb/tb_pxs_sync_gen.sv
// Self-checking bench for pxs_sync_gen using a reduced timing geometry so
// several whole frames fit in a short run.
module tb_pxs_sync_gen;

  localparam int HV = 80, HF = 4, HSY = 12, HB = 4;
  localparam int VV = 40, VF = 3, VSY = 2, VB = 5;
  localparam int HT = HV + HF + HSY + HB;
  localparam int VT = VV + VF + VSY + VB;
  localparam int FT = HT * VT;
  localparam logic [25:0] RST_VAL = {1'b1, 1'b1, 24'd0};

  logic        px_clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic [2:0]  solid_rgb = 3'd0;
  logic [25:0] RGBStr_o;
  logic        frame_end;

  int total = 0;
  int bad = 0;
  int t = 0;
  int last_x = 0, last_y = 0;
  int last_fe = -1;
  int hs_run = 0, act_run = 0;
  logic [1:0] m_mode = 2'd0;
  logic [2:0] m_solid = 3'd0;

  pxs_sync_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB)
  ) dut (
    .px_clk(px_clk), .reset(reset), .mode(mode), .solid_rgb(solid_rgb),
    .RGBStr_o(RGBStr_o), .frame_end(frame_end)
  );

  always #5 px_clk = ~px_clk;

  // Reference pixel computed straight from the timing and pattern rules.
  function automatic logic [25:0] exp_px(input int x, input int y, input logic [1:0] m, input logic [2:0] s);
    logic act, hs, vs;
    logic [2:0] rgb;
    act = (x < HV) && (y < VV);
    hs  = !((x >= HV + HF) && (x < HV + HF + HSY));
    vs  = !((y >= VV + VF) && (y < VV + VF + VSY));
    rgb = 3'd0;
    if (act) begin
      case (m)
        2'd1:    rgb = 3'(7 - x / (HV / 8));
        2'd2:    rgb = (((x / 32) % 2) != ((y / 32) % 2)) ? 3'd7 : 3'd0;
        2'd3:    rgb = s;
        default: rgb = 3'd0;
      endcase
    end
    return {hs, vs, act, 10'(y), 10'(x), rgb};
  endfunction

  task automatic chk26(input string tag, input logic [25:0] obs, input logic [25:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic run_cycles(input int n, input bit rnd);
    int x, y;
    for (int i = 0; i < n; i++) begin
      @(posedge px_clk);
      #1;
      if (t % FT == 0) begin
        m_mode  = mode;
        m_solid = solid_rgb;
      end
      x = t % HT;
      y = (t / HT) % VT;
      chk26("pixel", RGBStr_o, exp_px(x, y, m_mode, m_solid));
      chk_int("frame_end", int'(frame_end), ((x == HV - 1) && (y == VV - 1)) ? 1 : 0);
      if (!RGBStr_o[25]) begin
        hs_run++;
      end else if (hs_run != 0) begin
        chk_int("hs_width", hs_run, HSY);
        hs_run = 0;
      end
      act_run += int'(RGBStr_o[23]);
      if (x == HT - 1) begin
        chk_int("active_per_line", act_run, (y < VV) ? HV : 0);
        act_run = 0;
      end
      if (frame_end) begin
        if (last_fe < 0) chk_int("fe_first", t, (VV - 1) * HT + HV - 1);
        else             chk_int("fe_period", t - last_fe, FT);
        last_fe = t;
      end
      last_x = x;
      last_y = y;
      t++;
      if (rnd && ($urandom_range(0, 149) == 0)) begin
        mode      = 2'($urandom);
        solid_rgb = 3'($urandom);
      end
    end
  endtask

  task automatic run_until(input int px, input int py);
    int n;
    n = 0;
    do begin
      run_cycles(1, 1'b0);
      n++;
    end while (!((last_x == px) && (last_y == py)) && (n <= FT));
    chk_int("reached_point", ((last_x == px) && (last_y == py)) ? 1 : 0, 1);
  endtask

  initial begin
    mode = 2'd1;
    repeat (3) @(posedge px_clk);
    #1;
    chk26("reset_stream", RGBStr_o, RST_VAL);
    chk_int("reset_frame_end", int'(frame_end), 0);
    @(negedge px_clk);
    reset = 1'b0;

    // Colour bars sampled at the first edge after release.
    run_until(0, 0);
    chk26("first_pixel", RGBStr_o & 26'h3FFFFF8, {1'b1, 1'b1, 1'b1, 23'd0});
    chk_int("bar_x0", int'(RGBStr_o[2:0]), 7);
    run_until(HV / 8, 0);
    chk_int("bar_x1", int'(RGBStr_o[2:0]), 6);
    run_until(HV - 1, 0);
    chk_int("bar_last", int'(RGBStr_o[2:0]), 0);
    run_until(HV + 10, 0);
    chk_int("bar_blank", int'(RGBStr_o[2:0]), 0);

    // Black frame, then a mid-frame switch to checkerboard.
    run_until(0, VV + 5);
    mode = 2'd0;
    run_until(0, 0);
    run_until(0, 10);
    mode = 2'd2;
    run_until(40, 30);
    chk_int("no_tear", int'(RGBStr_o[2:0]), 0);
    run_until(0, 0);
    chk_int("chk_0_0", int'(RGBStr_o[2:0]), 0);
    run_until(32, 0);
    chk_int("chk_32_0", int'(RGBStr_o[2:0]), 7);
    run_until(32, 32);
    chk_int("chk_32_32", int'(RGBStr_o[2:0]), 0);

    // Randomised mode/colour changes across two frames.
    run_cycles(2 * FT, 1'b1);

    // Mid-frame reset: asynchronous clear, then restart at (0,0).
    run_until(30, 20);
    @(negedge px_clk);
    reset = 1'b1;
    #1;
    chk26("async_reset_stream", RGBStr_o, RST_VAL);
    chk_int("async_reset_fe", int'(frame_end), 0);
    repeat (3) begin
      @(posedge px_clk);
      #1;
      chk26("held_reset_stream", RGBStr_o, RST_VAL);
    end
    mode      = 2'd3;
    solid_rgb = 3'd5;
    @(negedge px_clk);
    reset   = 1'b0;
    t       = 0;
    last_fe = -1;
    hs_run  = 0;
    act_run = 0;
    run_cycles(1, 1'b0);
    chk_int("restart_x", int'(RGBStr_o[12:3]), 0);
    chk_int("restart_y", int'(RGBStr_o[22:13]), 0);
    chk_int("restart_solid", int'(RGBStr_o[2:0]), 5);
    run_cycles(FT + 200, 1'b1);
    chk_int("fe_seen_after_reset", (last_fe >= 0) ? 1 : 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
